axi_decerr_slave: RTL and testbench

//  Parametrised AXI default slave. Sits on the interconnect's unmapped-address port and absorbs any
//  AR/AW that no real slave decodes. Replies with an error response. Supports full INCR bursts.

---
 rtl/axi_ds_pkg.sv | 14 +
 rtl/axi_decerr_slave_if.sv | 51 +++++
 rtl/axi_ds_beat_cnt.sv | 22 ++
 rtl/axi_decerr_slave.sv | 122 ++++++++++++
 tb/tb_axi_decerr_slave.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_ds_pkg.sv
// Shared types for the AXI default (decode-error) slave: FSM states, response codes and a saturating counter helper.
package axi_ds_pkg;

   typedef enum logic {R_IDLE, R_BURST} rd_state_e;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
   typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_e;

   localparam logic [1:0] RESP_DECERR = 2'b11;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/axi_decerr_slave_if.sv
// AXI bus bundle seen by the default slave; W payload is not carried since every beat is discarded.
interface axi_decerr_slave_if #(
   parameter int ID_WIDTH   = 8,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 4
);
   logic [ID_WIDTH-1:0]   ARID;
   logic [ADDR_WIDTH-1:0] ARADDR;
   logic [LEN_WIDTH-1:0]  ARLEN;
   logic                  ARVALID;
   logic                  ARREADY;

   logic [ID_WIDTH-1:0]   RID;
   logic [DATA_WIDTH-1:0] RDATA;
   logic [1:0]            RRESP;
   logic                  RLAST;
   logic                  RVALID;
   logic                  RREADY;

   logic [ID_WIDTH-1:0]   AWID;
   logic [ADDR_WIDTH-1:0] AWADDR;
   logic [LEN_WIDTH-1:0]  AWLEN;
   logic                  AWVALID;
   logic                  AWREADY;

   logic                  WLAST;
   logic                  WVALID;
   logic                  WREADY;

   logic [ID_WIDTH-1:0]   BID;
   logic [1:0]            BRESP;
   logic                  BVALID;
   logic                  BREADY;

   modport slave (
      input  ARID, ARADDR, ARLEN, ARVALID, output ARREADY,
      output RID, RDATA, RRESP, RLAST, RVALID, input RREADY,
      input  AWID, AWADDR, AWLEN, AWVALID, output AWREADY,
      input  WLAST, WVALID, output WREADY,
      output BID, BRESP, BVALID, input BREADY
   );

   modport master (
      output ARID, ARADDR, ARLEN, ARVALID, input ARREADY,
      input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY,
      output AWID, AWADDR, AWLEN, AWVALID, input AWREADY,
      output WLAST, WVALID, input WREADY,
      input  BID, BRESP, BVALID, output BREADY
   );
endinterface

// File: rtl/axi_ds_beat_cnt.sv
// Burst beat down-counter: loaded with LEN, decremented per accepted beat, is_last flags the final beat.
module axi_ds_beat_cnt #(
   parameter int LEN_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 load,
   input  logic [LEN_WIDTH-1:0] load_val,
   input  logic                 dec,
   output logic                 is_last
);
   logic [LEN_WIDTH-1:0] cnt_q;

   // Counter only has meaning inside a burst, so it carries no reset.
   always_ff @(posedge clk) begin
      if (load)
         cnt_q <= load_val;
      else if (dec)
         cnt_q <= cnt_q - 1'b1;
   end

   assign is_last = (cnt_q == '0);
endmodule

// File: rtl/axi_decerr_slave.sv
// AXI default slave answering every AR/AW with RESP_CODE; optional error log enabled by AXI_DS_ERRLOG_EN.
module axi_decerr_slave
   import axi_ds_pkg::*;
#(
   parameter int                    ID_WIDTH   = 8,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    LEN_WIDTH  = 4,
   parameter logic [1:0]            RESP_CODE  = RESP_DECERR,
   parameter logic [DATA_WIDTH-1:0] RDATA_FILL = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   axi_decerr_slave_if.slave     axi
`ifdef AXI_DS_ERRLOG_EN
   ,
   output logic [15:0]           rd_err_cnt,
   output logic [15:0]           wr_err_cnt,
   output logic [ADDR_WIDTH-1:0] last_err_addr
`endif
);
   rd_state_e rd_state_q, rd_state_d;
   wr_state_e wr_state_q, wr_state_d;
   logic arready_q, arready_d;
   logic awready_q, awready_d;
   logic [ID_WIDTH-1:0] rid_q, bid_q;
   logic rvalid, wready, bvalid, rd_last;
   logic ar_hs, r_hs, aw_hs;

   assign rvalid = (rd_state_q == R_BURST);
   assign wready = (wr_state_q == W_DATA);
   assign bvalid = (wr_state_q == W_RESP);
   assign ar_hs  = axi.ARVALID & arready_q;
   assign aw_hs  = axi.AWVALID & awready_q;
   assign r_hs   = rvalid & axi.RREADY;

   axi_ds_beat_cnt #(.LEN_WIDTH(LEN_WIDTH)) u_rd_cnt (
      .clk      (clk),
      .load     (ar_hs),
      .load_val (axi.ARLEN),
      .dec      (r_hs),
      .is_last  (rd_last)
   );

   // Ready flags are registered copies of "next state is idle", so they stay low through reset.
   always_comb begin
      rd_state_d = rd_state_q;
      case (rd_state_q)
         R_IDLE:  if (ar_hs) rd_state_d = R_BURST;
         R_BURST: if (r_hs && rd_last) rd_state_d = R_IDLE;
         default: rd_state_d = R_IDLE;
      endcase
      arready_d = (rd_state_d == R_IDLE);
   end

   always_comb begin
      wr_state_d = wr_state_q;
      case (wr_state_q)
         W_IDLE:  if (aw_hs) wr_state_d = W_DATA;
         W_DATA:  if (axi.WVALID && axi.WLAST) wr_state_d = W_RESP;
         W_RESP:  if (axi.BREADY) wr_state_d = W_IDLE;
         default: wr_state_d = W_IDLE;
      endcase
      awready_d = (wr_state_d == W_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state_q <= R_IDLE;
         wr_state_q <= W_IDLE;
         arready_q  <= 1'b0;
         awready_q  <= 1'b0;
      end else begin
         rd_state_q <= rd_state_d;
         wr_state_q <= wr_state_d;
         arready_q  <= arready_d;
         awready_q  <= awready_d;
      end
   end

   always_ff @(posedge clk) begin
      if (ar_hs) rid_q <= axi.ARID;
      if (aw_hs) bid_q <= axi.AWID;
   end

   // Payload is gated by VALID so every output reads zero while idle or in reset.
   assign axi.ARREADY = arready_q;
   assign axi.RVALID  = rvalid;
   assign axi.RID     = rvalid ? rid_q : '0;
   assign axi.RRESP   = rvalid ? RESP_CODE : OKAY;
   assign axi.RDATA   = rvalid ? RDATA_FILL : '0;
   assign axi.RLAST   = rvalid & rd_last;
   assign axi.AWREADY = awready_q;
   assign axi.WREADY  = wready;
   assign axi.BVALID  = bvalid;
   assign axi.BID     = bvalid ? bid_q : '0;
   assign axi.BRESP   = bvalid ? RESP_CODE : OKAY;

`ifdef AXI_DS_ERRLOG_EN
   // AW takes priority for the captured address when both handshakes land together.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_err_cnt    <= '0;
         wr_err_cnt    <= '0;
         last_err_addr <= '0;
      end else begin
         if (ar_hs) rd_err_cnt <= sat_inc16(rd_err_cnt);
         if (aw_hs) wr_err_cnt <= sat_inc16(wr_err_cnt);
         if (aw_hs)
            last_err_addr <= axi.AWADDR;
         else if (ar_hs)
            last_err_addr <= axi.ARADDR;
      end
   end
`else
   logic [ADDR_WIDTH-1:0] unused_addr;
   assign unused_addr = axi.ARADDR ^ axi.AWADDR;
`endif

   logic unused_awlen;
   assign unused_awlen = ^axi.AWLEN;
endmodule

// File: tb/tb_axi_decerr_slave.sv
// Randomized self-checking bench for axi_decerr_slave; error-log checks compile in with AXI_DS_ERRLOG_EN.
module tb_axi_decerr_slave;
   localparam int IDW = 8;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LW  = 4;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   // Reference model of the error log: handshake counts and the address of the latest one.
   int          exp_rd = 0;
   int          exp_wr = 0;
   logic [AW-1:0] ar_last_addr = '0, aw_last_addr = '0;
   time         ar_last_t = 0, aw_last_t = 0;

   axi_decerr_slave_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

`ifdef AXI_DS_ERRLOG_EN
   logic [15:0]   rd_err_cnt, wr_err_cnt;
   logic [AW-1:0] last_err_addr;
`endif

   axi_decerr_slave #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk (clk),
      .rst (rst),
      .axi (bus)
`ifdef AXI_DS_ERRLOG_EN
      ,
      .rd_err_cnt    (rd_err_cnt),
      .wr_err_cnt    (wr_err_cnt),
      .last_err_addr (last_err_addr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic read_txn(input logic [IDW-1:0] id, input logic [LW-1:0] len,
                           input int rready_pct, output int cycles);
      int guard;
      int k;
      logic rr;
      logic [AW-1:0] addr;
      cycles = 0;
      addr = $urandom;
      bus.ARID = id; bus.ARLEN = len; bus.ARADDR = addr; bus.ARVALID = 1'b1;
      guard = 0;
      while (bus.ARREADY !== 1'b1 && guard < 50) begin step(); guard++; end
      if (guard == 50) begin
         checks++; errors++;
         $display("FAIL ar_timeout: ARREADY=%b required 1", bus.ARREADY);
         bus.ARVALID = 1'b0;
         return;
      end
      checks++;
      if (bus.RVALID !== 1'b0) begin
         errors++; $display("FAIL r_before_ar: RVALID=%b required 0", bus.RVALID);
      end
      step();
      exp_rd++; ar_last_addr = addr; ar_last_t = $time;
      bus.ARVALID = 1'b0;
      k = 0;
      while (k <= int'(len)) begin
         rr = ($urandom_range(99) < rready_pct);
         bus.RREADY = rr;
         checks++;
         if ({bus.RVALID, bus.ARREADY, bus.RID, bus.RRESP, bus.RDATA, bus.RLAST} !==
             {1'b1, 1'b0, id, 2'b11, {DW{1'b0}}, (k == int'(len))}) begin
            errors++;
            $display("FAIL r_beat %0d: got vld=%b ardy=%b id=%h resp=%b data=%h last=%b required vld=1 ardy=0 id=%h resp=11 data=0 last=%b",
                     k, bus.RVALID, bus.ARREADY, bus.RID, bus.RRESP, bus.RDATA, bus.RLAST, id, (k == int'(len)));
         end
         step();
         cycles++;
         if (rr) k++;
         if (cycles > 500) begin
            checks++; errors++;
            $display("FAIL r_timeout: beats=%0d required %0d", k, int'(len) + 1);
            break;
         end
      end
      bus.RREADY = 1'b0;
      checks++;
      if ({bus.RVALID, bus.ARREADY} !== 2'b01) begin
         errors++; $display("FAIL r_end: RVALID=%b ARREADY=%b required 0 1", bus.RVALID, bus.ARREADY);
      end
   endtask

   task automatic write_txn(input logic [IDW-1:0] id, input logic [LW-1:0] awlen, input int nbeats,
                            input int wvalid_pct, input int bdelay, output int cycles);
      int guard;
      int k;
      logic wv;
      logic [AW-1:0] addr;
      cycles = 0;
      addr = $urandom;
      bus.AWID = id; bus.AWLEN = awlen; bus.AWADDR = addr; bus.AWVALID = 1'b1;
      guard = 0;
      while (bus.AWREADY !== 1'b1 && guard < 50) begin step(); guard++; end
      if (guard == 50) begin
         checks++; errors++;
         $display("FAIL aw_timeout: AWREADY=%b required 1", bus.AWREADY);
         bus.AWVALID = 1'b0;
         return;
      end
      checks++;
      if ({bus.WREADY, bus.BVALID} !== 2'b00) begin
         errors++; $display("FAIL w_before_aw: WREADY=%b BVALID=%b required 0 0", bus.WREADY, bus.BVALID);
      end
      step();
      exp_wr++; aw_last_addr = addr; aw_last_t = $time;
      bus.AWVALID = 1'b0;
      k = 1;
      while (k <= nbeats) begin
         wv = ($urandom_range(99) < wvalid_pct);
         bus.WVALID = wv;
         bus.WLAST  = wv && (k == nbeats);
         checks++;
         if ({bus.WREADY, bus.AWREADY, bus.BVALID} !== 3'b100) begin
            errors++;
            $display("FAIL w_beat %0d: WREADY=%b AWREADY=%b BVALID=%b required 1 0 0",
                     k, bus.WREADY, bus.AWREADY, bus.BVALID);
         end
         step();
         cycles++;
         if (wv) k++;
         if (cycles > 500) begin
            checks++; errors++;
            $display("FAIL w_timeout: beats=%0d required %0d", k - 1, nbeats);
            break;
         end
      end
      bus.WVALID = 1'b0; bus.WLAST = 1'b0;
      for (int d = 0; d <= bdelay; d++) begin
         bus.BREADY = (d == bdelay);
         checks++;
         if ({bus.BVALID, bus.WREADY, bus.BID, bus.BRESP} !== {1'b1, 1'b0, id, 2'b11}) begin
            errors++;
            $display("FAIL b_resp: BVALID=%b WREADY=%b BID=%h BRESP=%b required 1 0 %h 11",
                     bus.BVALID, bus.WREADY, bus.BID, bus.BRESP, id);
         end
         step();
      end
      bus.BREADY = 1'b0;
      checks++;
      if ({bus.BVALID, bus.AWREADY, bus.WREADY} !== 3'b010) begin
         errors++;
         $display("FAIL b_end: BVALID=%b AWREADY=%b WREADY=%b required 0 1 0", bus.BVALID, bus.AWREADY, bus.WREADY);
      end
   endtask

   task automatic pulse_reset(input int n);
      rst = 1'b1;
      repeat (n) step();
      rst = 1'b0;
      step();
      exp_rd = 0; exp_wr = 0;
      ar_last_addr = '0; aw_last_addr = '0; ar_last_t = 0; aw_last_t = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({bus.ARREADY, bus.AWREADY, bus.WREADY, bus.RVALID, bus.RLAST, bus.BVALID,
              bus.RID, bus.RRESP, bus.RDATA, bus.BID, bus.BRESP} !== '0) begin
            errors++;
            $display("FAIL reset_outputs cycle %0d: ardy=%b awrdy=%b wrdy=%b rvld=%b rlast=%b bvld=%b rid=%h rresp=%b rdata=%h bid=%h bresp=%b required all 0",
                     i, bus.ARREADY, bus.AWREADY, bus.WREADY, bus.RVALID, bus.RLAST, bus.BVALID,
                     bus.RID, bus.RRESP, bus.RDATA, bus.BID, bus.BRESP);
         end
`ifdef AXI_DS_ERRLOG_EN
         checks++;
         if ({rd_err_cnt, wr_err_cnt, last_err_addr} !== '0) begin
            errors++; $display("FAIL reset_log: rd=%0d wr=%0d addr=%h required 0", rd_err_cnt, wr_err_cnt, last_err_addr);
         end
`endif
      end
      rst = 1'b0;
      step();
      checks++;
      if ({bus.ARREADY, bus.AWREADY, bus.WREADY} !== 3'b110) begin
         errors++;
         $display("FAIL reset_release: ARREADY=%b AWREADY=%b WREADY=%b required 1 1 0", bus.ARREADY, bus.AWREADY, bus.WREADY);
      end
   endtask

   task automatic test_read_burst();
      int c;
      read_txn(8'h5A, 4'd3, 100, c);
      checks++;
      if (c !== 4) begin errors++; $display("FAIL read_burst_cycles: %0d required 4", c); end
   endtask

   task automatic test_read_stall();
      int c;
      bus.ARID = 8'hC3; bus.ARLEN = 4'd0; bus.ARADDR = 32'h1000; bus.ARVALID = 1'b1;
      step();
      exp_rd++; ar_last_addr = 32'h1000; ar_last_t = $time;
      bus.ARVALID = 1'b0;
      bus.RREADY = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({bus.RVALID, bus.RLAST, bus.RID, bus.RRESP} !== {1'b1, 1'b1, 8'hC3, 2'b11}) begin
            errors++;
            $display("FAIL read_stall cycle %0d: vld=%b last=%b id=%h resp=%b required 1 1 c3 11",
                     i, bus.RVALID, bus.RLAST, bus.RID, bus.RRESP);
         end
         step();
      end
      bus.RREADY = 1'b1;
      step();
      bus.RREADY = 1'b0;
      checks++;
      if ({bus.RVALID, bus.ARREADY} !== 2'b01) begin
         errors++; $display("FAIL read_stall_end: RVALID=%b ARREADY=%b required 0 1", bus.RVALID, bus.ARREADY);
      end
      c = 0;
   endtask

   task automatic test_write_early_last();
      int c;
      write_txn(8'h21, 4'd7, 2, 100, 2, c);
      checks++;
      if (c !== 2) begin errors++; $display("FAIL write_early_last_cycles: %0d required 2", c); end
   endtask

   task automatic test_concurrent();
      int rc, wc;
      fork
         read_txn(8'h77, 4'd15, 100, rc);
         write_txn(8'h88, 4'd2, 3, 100, 0, wc);
      join
      checks++;
      if (rc !== 16 || wc !== 3) begin
         errors++; $display("FAIL concurrent_cycles: r=%0d w=%0d required 16 3", rc, wc);
      end
`ifdef AXI_DS_ERRLOG_EN
      checks++;
      if (last_err_addr !== ((aw_last_t >= ar_last_t) ? aw_last_addr : ar_last_addr)) begin
         errors++; $display("FAIL concurrent_addr: %h required %h", last_err_addr, aw_last_addr);
      end
`endif
   endtask

   task automatic test_random();
      int rc, wc;
      for (int i = 0; i < 10; i++) begin
         logic [IDW-1:0] rid, wid;
         logic [LW-1:0]  rlen, awlen;
         rid = IDW'($urandom); wid = IDW'($urandom);
         rlen = LW'($urandom); awlen = LW'($urandom);
         if ($urandom_range(1) == 1) begin
            fork
               read_txn(rid, rlen, $urandom_range(100, 30), rc);
               write_txn(wid, awlen, $urandom_range(6, 1), $urandom_range(100, 40), $urandom_range(3), wc);
            join
         end else begin
            read_txn(rid, rlen, $urandom_range(100, 30), rc);
            write_txn(wid, awlen, $urandom_range(6, 1), $urandom_range(100, 40), $urandom_range(3), wc);
         end
      end
`ifdef AXI_DS_ERRLOG_EN
      checks++;
      if ({rd_err_cnt, wr_err_cnt} !== {16'(exp_rd), 16'(exp_wr)}) begin
         errors++; $display("FAIL random_counts: rd=%0d wr=%0d required %0d %0d", rd_err_cnt, wr_err_cnt, exp_rd, exp_wr);
      end
`endif
   endtask

   task automatic test_reset_mid_burst();
      int c;
      int guard;
      pulse_reset(2);
      for (int i = 0; i < 3; i++) read_txn(IDW'($urandom), LW'($urandom_range(3)), 100, c);
      for (int i = 0; i < 2; i++) write_txn(IDW'($urandom), LW'($urandom), $urandom_range(3, 1), 100, 0, c);
`ifdef AXI_DS_ERRLOG_EN
      checks++;
      if ({rd_err_cnt, wr_err_cnt, last_err_addr} !== {16'd3, 16'd2, aw_last_addr}) begin
         errors++;
         $display("FAIL log_before_reset: rd=%0d wr=%0d addr=%h required 3 2 %h", rd_err_cnt, wr_err_cnt, last_err_addr, aw_last_addr);
      end
`endif
      bus.ARID = 8'h3C; bus.ARLEN = 4'd15; bus.ARADDR = 32'hDEAD0000; bus.ARVALID = 1'b1;
      guard = 0;
      while (bus.ARREADY !== 1'b1 && guard < 20) begin step(); guard++; end
      step();
      bus.ARVALID = 1'b0;
      bus.RREADY = 1'b1;
      repeat (3) step();
      checks++;
      if (bus.RVALID !== 1'b1) begin errors++; $display("FAIL mid_burst_active: RVALID=%b required 1", bus.RVALID); end
      rst = 1'b1;
      step();
      checks++;
      if ({bus.RVALID, bus.ARREADY, bus.AWREADY, bus.WREADY, bus.BVALID, bus.RLAST} !== '0) begin
         errors++;
         $display("FAIL mid_burst_reset: rvld=%b ardy=%b awrdy=%b wrdy=%b bvld=%b rlast=%b required all 0",
                  bus.RVALID, bus.ARREADY, bus.AWREADY, bus.WREADY, bus.BVALID, bus.RLAST);
      end
`ifdef AXI_DS_ERRLOG_EN
      checks++;
      if ({rd_err_cnt, wr_err_cnt, last_err_addr} !== '0) begin
         errors++; $display("FAIL log_after_reset: rd=%0d wr=%0d addr=%h required 0", rd_err_cnt, wr_err_cnt, last_err_addr);
      end
`endif
      rst = 1'b0;
      bus.RREADY = 1'b0;
      step();
      exp_rd = 0; exp_wr = 0;
      checks++;
      if ({bus.RVALID, bus.ARREADY, bus.AWREADY} !== 3'b011) begin
         errors++;
         $display("FAIL after_reset_idle: RVALID=%b ARREADY=%b AWREADY=%b required 0 1 1", bus.RVALID, bus.ARREADY, bus.AWREADY);
      end
      read_txn(8'h99, 4'd1, 100, c);
   endtask

   initial begin
      rst = 1'b1;
      bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARVALID = 1'b0;
      bus.RREADY = 1'b0;
      bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWVALID = 1'b0;
      bus.WLAST = 1'b0; bus.WVALID = 1'b0;
      bus.BREADY = 1'b0;
      test_reset();
      test_read_burst();
      test_read_stall();
      test_write_early_last();
      test_concurrent();
      test_random();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
